// File: rtl/ts_null_stuffer.sv
// Constant-rate TS output stage: buffers up to two 188-byte packets and emits a gap-free
// byte-per-clock stream, stuffing null packets when none is ready. Define NULL_CNT_EN for NULL_CNT.
//
// state      | meaning
// HUNT       | waiting for a qualified 0x47 sync byte to start a packet
// FILL       | writing packet bytes into the slot at the write pointer
// START      | first cycle after reset, nothing issued yet
// SEND_DATA  | reading a buffered packet out of the read-pointer slot
// SEND_NULL  | emitting a null packet (PID 0x1FFF)

module ts_null_stuffer #(
    parameter int PKT_LEN = 188
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  DATA_IN,
    input  logic        D_VALID_IN,
    input  logic        P_SYNC_IN,
    output logic [7:0]  DATA_OUT,
    output logic        D_VALID_OUT,
    output logic        P_SYNC_OUT,
    output logic        OVERFLOW
`ifdef NULL_CNT_EN
    ,
    output logic [15:0] NULL_CNT
`endif
);

    localparam int IW = $clog2(PKT_LEN);
    localparam int AW = $clog2(2 * PKT_LEN);
    localparam logic [IW-1:0] LAST = IW'(PKT_LEN - 1);

    typedef enum logic {HUNT, FILL} wr_state_t;
    typedef enum logic [1:0] {START, SEND_DATA, SEND_NULL} rd_state_t;

    logic [7:0]    mem [0:2*PKT_LEN-1];
    logic [7:0]    ram_q;

    wr_state_t     wr_state;
    logic          wr_ptr;
    logic [IW-1:0] wr_idx;
    rd_state_t     rd_state;
    logic          rd_ptr;
    logic [IW-1:0] rd_cnt;
    logic [1:0]    full;

    logic          sync_ok;
    logic          restart;
    logic          wr_en;
    logic          wr_done;
    logic [IW-1:0] wr_at;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          decide;
    logic          send_data;
    logic          rd_done;

    logic          s1_valid;
    logic          s1_sync;
    logic          s1_data;
    logic [IW-1:0] s1_cnt;

    function automatic logic [7:0] null_byte(input logic [IW-1:0] idx);
        if (idx == IW'(0))      return 8'h47;
        else if (idx == IW'(1)) return 8'h1F;
        else if (idx == IW'(3)) return 8'h10;
        else                    return 8'hFF;
    endfunction

    // A sync inside FILL before the last byte abandons the partial packet and is re-judged as a HUNT start.
    always_comb begin
        sync_ok = D_VALID_IN && P_SYNC_IN && (DATA_IN == 8'h47);
        restart = (wr_state == HUNT) || (D_VALID_IN && P_SYNC_IN && (wr_idx < LAST));
        wr_en   = 1'b0;
        wr_at   = wr_idx;
        wr_done = 1'b0;
        if (restart) begin
            if (sync_ok && !full[wr_ptr]) begin
                wr_en = 1'b1;
                wr_at = '0;
            end
        end else if (D_VALID_IN) begin
            wr_en   = 1'b1;
            wr_done = (wr_idx == LAST);
        end
        wr_addr = wr_ptr ? AW'(PKT_LEN) + AW'(wr_at) : AW'(wr_at);
    end

    always_comb begin
        decide    = (rd_cnt == '0);
        send_data = decide ? full[rd_ptr] : (rd_state == SEND_DATA);
        rd_done   = send_data && (rd_cnt == LAST);
        rd_addr   = rd_ptr ? AW'(PKT_LEN) + AW'(rd_cnt) : AW'(rd_cnt);
    end

    always_ff @(posedge CLK) begin
        if (RST && wr_en) mem[wr_addr] <= DATA_IN;
    end

    always_ff @(posedge CLK) begin
        ram_q <= mem[rd_addr];
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_state <= HUNT;
            wr_ptr   <= 1'b0;
            wr_idx   <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            OVERFLOW <= 1'b0;
            if (restart) begin
                if (sync_ok && !full[wr_ptr]) begin
                    wr_idx   <= IW'(1);
                    wr_state <= FILL;
                end else begin
                    wr_state <= HUNT;
                    if (sync_ok) OVERFLOW <= 1'b1;
                end
            end else if (D_VALID_IN) begin
                if (wr_idx == LAST) begin
                    wr_state <= HUNT;
                    wr_ptr   <= ~wr_ptr;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
        end
    end

    // Reader and writer never touch the same slot: the writer only claims slots that are not full.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            full <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rd_done && (rd_ptr == 1'(i))) full[i] <= 1'b0;
                if (wr_done && (wr_ptr == 1'(i))) full[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rd_state <= START;
            rd_ptr   <= 1'b0;
            rd_cnt   <= '0;
            s1_valid <= 1'b0;
            s1_sync  <= 1'b0;
            s1_data  <= 1'b0;
            s1_cnt   <= '0;
        end else begin
            rd_state <= send_data ? SEND_DATA : SEND_NULL;
            rd_cnt   <= (rd_cnt == LAST) ? '0 : rd_cnt + 1'b1;
            if (rd_done) rd_ptr <= ~rd_ptr;
            s1_valid <= 1'b1;
            s1_sync  <= decide;
            s1_data  <= send_data;
            s1_cnt   <= rd_cnt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            DATA_OUT    <= 8'h00;
            D_VALID_OUT <= 1'b0;
            P_SYNC_OUT  <= 1'b0;
`ifdef NULL_CNT_EN
            NULL_CNT    <= 16'h0000;
`endif
        end else begin
            DATA_OUT    <= !s1_valid ? 8'h00 : (s1_data ? ram_q : null_byte(s1_cnt));
            D_VALID_OUT <= s1_valid;
            P_SYNC_OUT  <= s1_valid && s1_sync;
`ifdef NULL_CNT_EN
            if (s1_valid && s1_sync && !s1_data && (NULL_CNT != 16'hFFFF))
                NULL_CNT <= NULL_CNT + 16'd1;
`endif
        end
    end

endmodule

// File: tb/tb_ts_null_stuffer.sv
// Bench for ts_null_stuffer: packet-queue reference model checked every cycle, plus directed
// scenarios with literal expectations on the output packet sequence and overflow pulses.
module tb_ts_null_stuffer;

    localparam int PL = 188;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       dvin;
    logic       psin;
    logic [7:0] dout;
    logic       dvout;
    logic       psout;
    logic       ovf;
`ifdef NULL_CNT_EN
    logic [15:0] ncnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    ts_null_stuffer #(.PKT_LEN(PL)) dut (
        .CLK(clk), .RST(rst), .DATA_IN(din), .D_VALID_IN(dvin), .P_SYNC_IN(psin),
        .DATA_OUT(dout), .D_VALID_OUT(dvout), .P_SYNC_OUT(psout), .OVERFLOW(ovf)
`ifdef NULL_CNT_EN
        , .NULL_CNT(ncnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s cyc=%0d (expected item missing)", nm, cyc);
    endtask

    // ---------------- reference model: completed packets held as a byte queue ----------------
    bit         m_live = 0;
    bit         m_hunt;
    logic [7:0] cur [PL];
    int         cur_len;
    logic [7:0] bq [$];
    int         m_cnt;
    bit         m_sending;
    logic [7:0] p_data;
    bit         p_valid, p_sync, p_null0;
    logic [7:0] e_data;
    bit         e_valid, e_sync, e_ovf;
    int         e_ncnt;

    function automatic logic [7:0] null_ref(input int i);
        case (i)
            0: return 8'h47;
            1: return 8'h1F;
            3: return 8'h10;
            default: return 8'hFF;
        endcase
    endfunction

    always @(posedge clk) begin : model
        int full_n;
        bit pop;
        cyc++;
        if (!rst) begin
            m_live = 1; m_hunt = 1; cur_len = 0; bq.delete();
            m_cnt = 0; m_sending = 0;
            p_valid = 0; p_sync = 0; p_data = 8'h00; p_null0 = 0;
            e_valid = 0; e_sync = 0; e_data = 8'h00; e_ovf = 0; e_ncnt = 0;
        end else if (m_live) begin
            full_n = bq.size() / PL;
            e_valid = p_valid; e_sync = p_sync; e_data = p_data;
            if (p_null0 && e_ncnt < 65535) e_ncnt++;
            if (m_cnt == 0) m_sending = (full_n > 0);
            p_valid = 1;
            p_sync  = (m_cnt == 0);
            p_data  = m_sending ? bq[m_cnt] : null_ref(m_cnt);
            p_null0 = (m_cnt == 0) && !m_sending;
            pop     = m_sending && (m_cnt == PL - 1);
            m_cnt   = (m_cnt + 1) % PL;
            e_ovf = 0;
            if (dvin) begin
                if (!m_hunt && psin && cur_len < PL - 1) m_hunt = 1;
                if (m_hunt) begin
                    if (psin && din == 8'h47) begin
                        if (full_n < 2) begin
                            cur[0] = din; cur_len = 1; m_hunt = 0;
                        end else begin
                            e_ovf = 1;
                        end
                    end
                end else begin
                    cur[cur_len] = din;
                    cur_len++;
                    if (cur_len == PL) begin
                        for (int i = 0; i < PL; i++) bq.push_back(cur[i]);
                        m_hunt = 1; cur_len = 0;
                    end
                end
            end
            if (pop) repeat (PL) void'(bq.pop_front());
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("DATA_OUT", 32'(dout), 32'(e_data));
            chk("D_VALID_OUT", 32'(dvout), 32'(e_valid));
            chk("P_SYNC_OUT", 32'(psout), 32'(e_sync));
            chk("OVERFLOW", 32'(ovf), 32'(e_ovf));
`ifdef NULL_CNT_EN
            chk("NULL_CNT", 32'(ncnt), 32'(e_ncnt));
`endif
        end
    end

    // ---------------- output log: byte 1 of every output packet, overflow pulses ----------------
    logic [7:0] log_q [$];
    bit         b1_pending = 0;
    int         ovf_cnt = 0;
    int         ovf_cyc = -1;
    int         last_sync_cyc = 0;

    always @(negedge clk) begin
        if (b1_pending) begin
            log_q.push_back(dout);
            b1_pending = 0;
        end
        if (psout === 1'b1) b1_pending = 1;
        if (ovf === 1'b1) begin
            ovf_cnt++;
            ovf_cyc = cyc;
        end
    end

    function automatic int count_tag(input logic [7:0] t);
        int n = 0;
        foreach (log_q[i]) if (log_q[i] == t) n++;
        return n;
    endfunction

    function automatic int find_tag(input logic [7:0] t);
        foreach (log_q[i]) if (log_q[i] == t) return i;
        return -1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dvin = 1'b0; psin = 1'($urandom); din = 8'($urandom);
        end
    endtask

    task automatic send_pkt(input logic [7:0] tag, input int gap, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0)) begin
                @(negedge clk);
                dvin = 1'b0; psin = 1'($urandom); din = 8'($urandom);
            end
            @(negedge clk);
            dvin = 1'b1;
            psin = (i == 0);
            din  = (i == 0) ? 8'h47 : (i == 1) ? tag : 8'($urandom);
            if (i == 0) last_sync_cyc = cyc + 1;
        end
    endtask

    task automatic wait_sync(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            dvin = 1'b0; psin = 1'b0;
            n++;
        end while (psout !== 1'b1 && n < 400);
        if (psout !== 1'b1) fail_now(nm);
    endtask

    task automatic expect_single(input string nm, input logic [7:0] t);
        int idx;
        chk({nm, "_count"}, 32'(count_tag(t)), 32'd1);
        idx = find_tag(t);
        if (idx >= 0 && idx + 1 < log_q.size()) chk({nm, "_next_null"}, 32'(log_q[idx + 1]), 32'h1F);
        else fail_now({nm, "_next_null"});
    endtask

    initial begin
        int idx;
        int r;
        logic [7:0] nf [$];
        rst = 1'b0; dvin = 1'b0; psin = 1'b0; din = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(dout), 32'h00);
        chk("rst_valid", 32'(dvout), 32'h0);
        chk("rst_sync", 32'(psout), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("start_valid", 32'(dvout), 32'h0);
        chk("start_sync", 32'(psout), 32'h0);
        @(negedge clk);
        chk("first_sync", 32'(psout), 32'h1);
        chk("first_byte", 32'(dout), 32'h47);
        chk("first_valid", 32'(dvout), 32'h1);
        @(negedge clk); chk("null_b1", 32'(dout), 32'h1F);
        @(negedge clk); chk("null_b2", 32'(dout), 32'hFF);
        @(negedge clk); chk("null_b3", 32'(dout), 32'h10);
        idle(2 * PL - 3);
`ifdef NULL_CNT_EN
        chk("null_cnt_3", 32'(ncnt), 32'd3);
`endif

        // single gap-free packet injected mid-null
        log_q.delete();
        idle($urandom_range(1, 150));
        send_pkt(8'h11, 0, PL);
        idle(2 * PL + 10);
        expect_single("single", 8'h11);

        // three back-to-back packets during a null: third one overflows
        wait_sync("t3_align");
        log_q.delete(); ovf_cnt = 0; ovf_cyc = -1;
        idle(50);
        send_pkt(8'hA0, 0, PL);
        send_pkt(8'hA1, 0, PL);
        send_pkt(8'hA2, 0, PL);
        idle(3 * PL);
        chk("t3_ovf_count", 32'(ovf_cnt), 32'd1);
        chk("t3_ovf_cycle", 32'(ovf_cyc), 32'(last_sync_cyc));
        nf.delete();
        foreach (log_q[i]) if (log_q[i] != 8'h1F) nf.push_back(log_q[i]);
        chk("t3_data_pkts", 32'(nf.size()), 32'd2);
        idx = find_tag(8'hA0);
        if (idx >= 0 && idx + 2 < log_q.size()) begin
            chk("t3_p1_follows", 32'(log_q[idx + 1]), 32'hA1);
            chk("t3_null_after", 32'(log_q[idx + 2]), 32'h1F);
        end else begin
            fail_now("t3_order");
        end

        // packet with a gap on every other cycle
        log_q.delete();
        idle($urandom_range(1, 150));
        send_pkt(8'h22, 1, PL);
        idle(2 * PL + 10);
        expect_single("gappy", 8'h22);

        // partial packet aborted by a new sync after 100 bytes
        log_q.delete();
        idle($urandom_range(1, 150));
        send_pkt(8'h32, 0, 100);
        send_pkt(8'h33, 0, PL);
        idle(2 * PL + 10);
        chk("abort_partial_absent", 32'(count_tag(8'h32)), 32'd0);
        expect_single("abort_full", 8'h33);

        // one-cycle reset while sending with both slots full
        wait_sync("t6_align");
        idle(10);
        send_pkt(8'h44, 0, PL);
        send_pkt(8'h45, 0, PL);
        idle(5);
        @(negedge clk);
        rst = 1'b0; dvin = 1'b0;
        @(negedge clk);
        chk("mid_rst_data", 32'(dout), 32'h00);
        chk("mid_rst_valid", 32'(dvout), 32'h0);
        chk("mid_rst_sync", 32'(psout), 32'h0);
        rst = 1'b1;
        log_q.delete();
        idle(3 * PL);
        chk("post_rst_pkts", 32'(log_q.size() >= 2), 32'd1);
        chk("post_rst_nulls_only", 32'(count_tag(8'h1F)), 32'(log_q.size()));

        // randomized traffic
        repeat (40) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                send_pkt(8'($urandom), $urandom_range(0, 2), PL);
            end else if (r == 5) begin
                send_pkt(8'($urandom), 0, $urandom_range(2, 150));
                send_pkt(8'($urandom), 2, PL);
            end else if (r == 6) begin
                idle($urandom_range(0, 300));
            end else if (r == 7) begin
                repeat ($urandom_range(1, 4)) begin
                    @(negedge clk);
                    dvin = 1'b1; psin = 1'b1; din = 8'($urandom);
                    if (din == 8'h47) din = 8'h48;
                end
            end else if (r == 8) begin
                idle($urandom_range(0, 20));
            end else begin
                @(negedge clk);
                rst = 1'b0; dvin = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end
        idle(2 * PL);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ts_null_stuffer.md
# ts_null_stuffer

Constant-rate TS output stage placed directly after the source switch, ahead of the pseudo-TS and ASI output pins. It absorbs the switch's bursty 188-byte packet stream into a two-packet buffer. It then emits an unbroken byte-per-clock transport stream, inserting standard null packets (PID 0x1FFF) whenever no complete packet is ready at a packet boundary. This gives the ASI transmitter a gap-free 27 MHz stream.

## Interface
Parameters:
- PKT_LEN, 188, bytes per TS packet; the buffer holds 2×PKT_LEN bytes.

Ports:
- CLK  in  1  system clock (27 MHz PLL output)
- RST  in  1  synchronous, active-low reset; one clock domain only
- DATA_IN  in  8  muxed TS byte from the source switch
- D_VALID_IN  in  1  DATA_IN qualifier; may drop low at any byte (gaps allowed)
- P_SYNC_IN  in  1  high with the first byte (0x47) of a packet, qualified by D_VALID_IN
- DATA_OUT  out  8  stuffed TS byte, registered
- D_VALID_OUT  out  1  high on every cycle after the start-up cycle
- P_SYNC_OUT  out  1  high with byte 0 of every output packet
- OVERFLOW  out  1  one-cycle pulse per dropped input packet
- NULL_CNT  out  16  count of null packets emitted (present only with NULL_CNT_EN)

## Operation
- Buffer: 2 slots × PKT_LEN bytes, single dual-port RAM. Each slot has a registered full flag. A 1-bit write pointer and a 1-bit read pointer select the slot.
- Write FSM, HUNT → FILL:
  - HUNT: on D_VALID_IN & P_SYNC_IN & DATA_IN==0x47:
    - if the slot at the write pointer is not full, write byte 0, set byte index to 1, go to FILL;
    - otherwise pulse OVERFLOW and stay in HUNT (whole packet dropped).
  - FILL: each D_VALID_IN byte is written at the current index, then the index increments.
    - After writing index PKT_LEN-1: set the slot's full flag, toggle the write pointer, go to HUNT.
    - A new P_SYNC_IN before index PKT_LEN-1 aborts the partial packet. Treat that byte as a fresh HUNT start in the same cycle, reusing the same slot.
  - Bytes with P_SYNC_IN but DATA_IN≠0x47 are ignored in HUNT.
- Read FSM, START → SEND_DATA / SEND_NULL:
  - Output byte counter runs 0..PKT_LEN-1 and wraps.
  - The decision is taken when the counter is at 0, using the registered full flag:
    - full flag of the read-pointer slot set → SEND_DATA;
    - otherwise → SEND_NULL.
  - SEND_DATA: bytes are read from the slot in order. After byte PKT_LEN-1 is issued, clear the full flag and toggle the read pointer.
  - SEND_NULL: emit 0x47, 0x1F, 0xFF, 0x10, then 184 × 0xFF.
- Simultaneous events:
  - A slot becoming full on the same cycle as a decision is not seen until the next boundary.
  - A slot freed by the reader on cycle N is writable by HUNT from cycle N+1.
- Reset mid-operation discards both slots and any partial packet; output restarts with the START cycle.

## Timing
- Reset values: DATA_OUT=0x00, D_VALID_OUT=0, P_SYNC_OUT=0, OVERFLOW=0, NULL_CNT=0. All full flags, pointers, indices and counters are 0. The write FSM is in HUNT; the read FSM is in START.
- START lasts 1 cycle after RST rises. The first output byte (a null packet byte 0, P_SYNC_OUT=1) appears on the second cycle after release.
- From then on, D_VALID_OUT=1 every cycle, and P_SYNC_OUT=1 exactly every PKT_LEN cycles.
- RAM read is registered: address is issued 1 cycle before DATA_OUT is updated. All outputs are flop outputs.
- Input-to-output latency:
  - minimum 2 cycles, from the cycle the last input byte is written to the output of that packet's byte 0;
  - maximum PKT_LEN+1 cycles when the other slot is being sent.
- Input throughput: one byte per clock; back-to-back packets with no gaps are accepted.

## Configuration
- NULL_CNT_EN:
  - Defined: NULL_CNT increments once when byte 0 of each null packet is emitted. It saturates at 0xFFFF and is cleared only by reset.
  - Undefined: the NULL_CNT port and counter are absent, and all other behaviour is identical.

## Test plan
- No input after reset → first P_SYNC_OUT on cycle 2. Output repeats 47 1F FF 10 FF×184, D_VALID_OUT constant 1. NULL_CNT=3 after 3×188 cycles.
- One gap-free packet (47, 00 01 ..) injected mid-null → emitted intact starting at the next boundary, then nulls resume. NULL_CNT excludes it.
- Three back-to-back packets P0,P1,P2 starting while a null is in progress → P0 and P1 are buffered. P2 drops, with OVERFLOW pulsing once on P2's sync byte. Output is P0 then P1 with no null between.
- Packet with D_VALID_IN low on every other cycle → output bytes identical to the gap-free case. Output stays continuous.
- P_SYNC_IN after 100 bytes of a packet, followed by a full 188-byte packet → the partial packet never appears, and only the second packet is emitted.
- RST low for 1 cycle while in SEND_DATA with both slots full → outputs take their reset values. Then nulls only, as the buffered packets are discarded.
